// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite bus bundle between a single master and the memory slave.
// Valid/ready rule: an address phase is taken only on an edge where HSEL=1, HTRANS[1]=1 and HREADY=1; a data phase ends on the first edge with HREADY=1.
interface ahb_mem_slave_if;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HTRANS, HWRITE, HADDR, HBURST, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HTRANS, HWRITE, HADDR, HBURST, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_mem_slave.sv
// AHB-Lite word memory slave with programmable wait states and a two-cycle ERROR response.
// The FSM state is exported on fsm_state (IDLE=0, WAIT=1, DONE=2, ERR1=3, ERR2=4).
module ahb_mem_slave #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           HCLK,
  input  logic           HRESET,
  ahb_mem_slave_if.slave bus,
  output logic [2:0]     fsm_state
);
  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] LIMIT     = 32'(DEPTH * 4);
  localparam logic [2:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DONE = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [2:0]       wait_cnt;
  logic [IDX_W-1:0] addr_q;
  logic             write_q;
  logic [31:0]      mem [DEPTH];
  logic [31:0]      rdata_q;

  logic             accept;
  logic             legal;
  logic             write_done;
  logic             rd_load;
  logic [IDX_W-1:0] haddr_idx;
  logic [IDX_W-1:0] rd_idx;

  // Burst type and the NONSEQ/SEQ distinction do not influence the response.
  logic unused_ok;
  assign unused_ok = ^{bus.HBURST, bus.HTRANS[0]};

  assign accept     = bus.HSEL && bus.HTRANS[1] && bus.HREADY;
  assign legal      = (bus.HADDR[1:0] == 2'b00) && (bus.HADDR < LIMIT);
  assign haddr_idx  = bus.HADDR[IDX_W+1:2];
  assign write_done = (state == S_DONE) && write_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_WAIT: if (wait_cnt == 3'd0) state_next = S_DONE;
      S_ERR1: state_next = S_ERR2;
      default: begin
        if (!accept)              state_next = S_IDLE;
        else if (!legal)          state_next = S_ERR1;
        else if (WAIT_CYCLES > 0) state_next = S_WAIT;
        else                      state_next = S_DONE;
      end
    endcase
  end

  always_comb begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 2'b00;
    case (state)
      S_WAIT: bus.HREADY = 1'b0;
      S_ERR1: begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 2'b01;
      end
      S_ERR2: bus.HRESP = 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wait_cnt <= 3'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= haddr_idx;
        write_q <= bus.HWRITE;
      end
      if (accept && legal)                     wait_cnt <= WAIT_LOAD;
      else if (state == S_WAIT && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // DONE is entered either from WAIT (registered address) or straight from an accept (live address).
  assign rd_idx  = (state == S_WAIT) ? addr_q : haddr_idx;
  assign rd_load = (state_next == S_DONE) && !((state == S_WAIT) ? write_q : bus.HWRITE);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rdata_q <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else begin
      if (write_done) mem[addr_q] <= bus.HWDATA;
      // A write retiring on the same edge must be visible to the read being loaded.
      if (rd_load) rdata_q <= (write_done && addr_q == rd_idx) ? bus.HWDATA : mem[rd_idx];
    end
  end

  assign bus.HRDATA = rdata_q;
  assign fsm_state  = state;
endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed and random checks of ahb_mem_slave for WAIT_CYCLES = 1, 0 and 3 against a word-array model.
module tb_ahb_mem_slave;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        hsel = 1'b0;
  logic [1:0]  htrans = T_IDLE;
  logic        hwrite = 1'b0;
  logic [31:0] haddr = 32'd0;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = 32'd0;

  logic        rdy_v   [3];
  logic [1:0]  resp_v  [3];
  logic [31:0] rdata_v [3];
  logic [2:0]  dbg_state [3];

  ahb_mem_slave_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    assign bus[g].HSEL   = hsel;
    assign bus[g].HTRANS = htrans;
    assign bus[g].HWRITE = hwrite;
    assign bus[g].HADDR  = haddr;
    assign bus[g].HBURST = hburst;
    assign bus[g].HWDATA = hwdata;
    assign rdy_v[g]      = bus[g].HREADY;
    assign resp_v[g]     = bus[g].HRESP;
    assign rdata_v[g]    = bus[g].HRDATA;
    ahb_mem_slave #(.DEPTH(16), .WAIT_CYCLES(WC)) dut (
      .HCLK(clk), .HRESET(rst), .bus(bus[g]), .fsm_state(dbg_state[g])
    );
  end

  int cfg = 0;
  int wc  = 1;
  logic        o_ready;
  logic [1:0]  o_resp;
  logic [31:0] o_rdata;
  assign o_ready = rdy_v[cfg];
  assign o_resp  = resp_v[cfg];
  assign o_rdata = rdata_v[cfg];

  // Reference model: 16 words, the currently expected HRDATA, and queued read results.
  logic [31:0] model_mem [16];
  logic [31:0] exp_rdata = 32'd0;
  logic [31:0] exp_q [$];
  logic [31:0] bdata [4];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic [1:0] resp, input logic [31:0] rd);
    chk({tag, ".hready"}, {31'd0, o_ready}, {31'd0, rdy});
    chk({tag, ".hresp"},  {30'd0, o_resp},  {30'd0, resp});
    chk({tag, ".hrdata"}, o_rdata, rd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0; haddr = 32'd0; hburst = 3'd0;
  endtask

  task automatic apply_reset(input int new_cfg, input int new_wc);
    bus_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cfg = new_cfg;
    wc  = new_wc;
    for (int i = 0; i < 16; i++) model_mem[i] = 32'd0;
    exp_rdata = 32'd0;
    exp_q.delete();
  endtask

  task automatic idle_cycle();
    hsel   = 1'($urandom_range(0, 1));
    htrans = hsel ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
    hwrite = 1'($urandom_range(0, 1));
    haddr  = $urandom;
    hwdata = $urandom;
    tick();
    chk_out("idle", 1'b1, 2'b00, exp_rdata);
  endtask

  // One non-pipelined transfer; the response shape comes from the address legality rule and wc.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic ok;
    int   idx;
    ok  = (addr[1:0] == 2'b00) && (addr < 32'd64);
    idx = int'(addr[5:2]);
    hsel = 1'b1; htrans = $urandom_range(0, 1) ? T_NSEQ : T_SEQ;
    hwrite = wr; haddr = addr; hburst = 3'($urandom_range(0, 7));
    if (ok && !wr) exp_q.push_back(model_mem[idx]);
    tick();
    hsel = 1'b0; htrans = T_IDLE; hwrite = 1'($urandom_range(0, 1)); haddr = $urandom;
    hwdata = data;
    if (ok) begin
      for (int i = 0; i < wc; i++) begin
        chk_out("wait", 1'b0, 2'b00, exp_rdata);
        tick();
      end
      if (!wr) exp_rdata = exp_q.pop_front();
      chk_out(wr ? "done_wr" : "done_rd", 1'b1, 2'b00, exp_rdata);
      tick();
      if (wr) model_mem[idx] = data;
    end else begin
      chk_out("err1", 1'b0, 2'b01, exp_rdata);
      tick();
      chk_out("err2", 1'b1, 2'b01, exp_rdata);
      tick();
    end
  endtask

  // Four pipelined beats at zero wait states: every data phase must finish with HREADY=1.
  task automatic burst4(input logic wr, input logic [31:0] base);
    int b;
    b = int'(base[5:2]);
    hsel = 1'b1; htrans = T_NSEQ; hwrite = wr; haddr = base; hburst = 3'b011;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!wr) exp_rdata = model_mem[b + i];
      chk_out(wr ? "burst_wr" : "burst_rd", 1'b1, 2'b00, exp_rdata);
      hwdata = bdata[i];
      if (wr) model_mem[b + i] = bdata[i];
      if (i < 3) begin
        htrans = T_SEQ; haddr = base + 32'(4 * (i + 1));
      end else begin
        hsel = 1'b0; htrans = T_IDLE;
      end
    end
    tick();
    chk_out("burst_end", 1'b1, 2'b00, exp_rdata);
  endtask

  task automatic random_run(input int n);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 9) < 2) begin
        idle_cycle();
      end else begin
        a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        case ($urandom_range(0, 9))
          0: a = a | 32'($urandom_range(1, 3));
          1: a = {$urandom_range(0, 32'hFFFF) , 2'b00} + 32'd64;
          2: a = a | 32'h8000_0000;
          default: ;
        endcase
        do_xfer(1'($urandom_range(0, 1)), a, $urandom);
      end
    end
  endtask

  initial begin
    // WAIT_CYCLES = 1
    apply_reset(0, 1);
    for (int i = 0; i < 3; i++) begin
      hsel = 1'b0; htrans = T_IDLE;
      tick();
      chk_out("reset_idle", 1'b1, 2'b00, 32'd0);
    end
    do_xfer(1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    do_xfer(1'b0, 32'h0000_0008, 32'd0);
    chk("wr_rd_deadbeef", o_rdata, 32'hDEAD_BEEF);
    do_xfer(1'b1, 32'h0000_0000, 32'h1111_2222);
    do_xfer(1'b0, 32'h0000_0040, 32'd0);
    do_xfer(1'b1, 32'h0000_0002, 32'hFFFF_FFFF);
    do_xfer(1'b0, 32'h0000_0000, 32'd0);
    chk("misaligned_nowrite", o_rdata, 32'h1111_2222);
    random_run(60);

    // WAIT_CYCLES = 0
    apply_reset(1, 0);
    hsel = 1'b1; htrans = T_NSEQ; hwrite = 1'b1; haddr = 32'h0000_000C;
    tick();
    chk_out("fwd_wr", 1'b1, 2'b00, exp_rdata);
    hwdata = 32'h1234_5678; htrans = T_NSEQ; hwrite = 1'b0; haddr = 32'h0000_000C;
    tick();
    model_mem[3] = 32'h1234_5678;
    exp_rdata    = 32'h1234_5678;
    chk_out("fwd_rd", 1'b1, 2'b00, 32'h1234_5678);
    bus_idle();
    tick();
    chk_out("fwd_end", 1'b1, 2'b00, exp_rdata);
    for (int i = 0; i < 4; i++) bdata[i] = $urandom;
    burst4(1'b1, 32'h0000_0010);
    burst4(1'b0, 32'h0000_0010);
    random_run(60);

    // WAIT_CYCLES = 3
    apply_reset(2, 3);
    do_xfer(1'b1, 32'h0000_0004, 32'h5A5A_5A5A);
    hsel = 1'b1; htrans = T_NSEQ; hwrite = 1'b1; haddr = 32'h0000_0004;
    tick();
    bus_idle();
    hwdata = 32'hA5A5_A5A5;
    chk_out("rst_wait1", 1'b0, 2'b00, exp_rdata);
    tick();
    chk_out("rst_wait2", 1'b0, 2'b00, exp_rdata);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 32'd0;
    exp_rdata = 32'd0;
    chk_out("rst_abort", 1'b1, 2'b00, 32'd0);
    do_xfer(1'b0, 32'h0000_0004, 32'd0);
    chk("rst_read_zero", o_rdata, 32'd0);
    random_run(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of 32-bit memory words, with a legal range of 4..256 (power of 2).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, meaning the number of wait states inserted per NONSEQ/SEQ data phase, with a legal range of 0..7.

Interface
REQ-003 The block SHALL have port HCLK, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port HRESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port HSEL, input, 1 bit: slave select.
REQ-006 The block SHALL have port HTRANS, input, 2 bits: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 The block SHALL have port HWRITE, input, 1 bit: 1 = write.
REQ-008 The block SHALL have port HADDR, input, 32 bits: byte address.
REQ-009 The block SHALL have port HBURST, input, 3 bits: accepted but not checked; burst order is the master's responsibility.
REQ-010 The block SHALL have port HWDATA, input, 32 bits: write data, valid in the data phase.
REQ-011 The block SHALL have port HREADY, output, 1 bit: transfer done; in a single-slave system it is also the address-phase qualifier.
REQ-012 The block SHALL have port HRESP, output, 2 bits: 00 OKAY, 01 ERROR.
REQ-013 The block SHALL have port HRDATA, output, 32 bits: read data.

Function
REQ-014 An address phase SHALL be accepted on a rising edge with HSEL=1, HTRANS[1]=1 and HREADY=1; the block SHALL register HADDR and HWRITE for the data phase.
REQ-015 IDLE/BUSY transfers, or HSEL=0, SHALL get a zero-wait OKAY response (HREADY=1, HRESP=00) and SHALL have no memory side effect.
REQ-016 An accepted address is legal if HADDR[1:0]=00 and HADDR < DEPTH*4; otherwise it is illegal.
REQ-017 The FSM SHALL have states IDLE, WAIT, DONE, ERR1 and ERR2.
REQ-018 From IDLE on accept: legal with WAIT_CYCLES>0 SHALL go to WAIT; legal with WAIT_CYCLES=0 SHALL go to DONE; illegal SHALL go to ERR1.
REQ-019 WAIT SHALL drive HREADY=0 and HRESP=00, decrement a 3-bit counter loaded with WAIT_CYCLES-1, and go to DONE when the counter is 0.
REQ-020 DONE SHALL drive HREADY=1 and HRESP=00.
REQ-021 In DONE a write SHALL store HWDATA into mem[addr[log2(DEPTH)+1:2]] at the edge ending DONE, and a read SHALL present the word on HRDATA.
REQ-022 From DONE, a new accept SHALL follow REQ-018 (pipelined back-to-back) and no accept SHALL go to IDLE.
REQ-023 ERR1 SHALL drive HREADY=0 and HRESP=01 and go to ERR2; ERR2 SHALL drive HREADY=1 and HRESP=01.
REQ-024 An address phase accepted during ERR2 SHALL be handled per REQ-018; an ERROR transfer SHALL never write memory.
REQ-025 HRDATA SHALL be registered: it is loaded on entry to DONE for reads, SHALL be stable throughout WAIT, and SHALL hold its last value in all other states.
REQ-026 With WAIT_CYCLES=0, if a read enters DONE on the same edge that a write to the same word completes, HRDATA SHALL take that HWDATA (forwarding).
REQ-027 HBURST SHALL have no effect on the response; SEQ is treated exactly as NONSEQ.

Reset
REQ-028 While HRESET=1 at a rising edge: FSM=IDLE, HREADY=1, HRESP=00, HRDATA=0, wait counter=0, and all memory words=0.
REQ-029 Reset asserted mid-WAIT or mid-ERR SHALL abort the transfer with no memory write, and the reset values SHALL appear the next cycle.

Verification
REQ-030 Reset then IDLE: after HRESET is released and HTRANS=00 is held for 3 cycles, the bench SHALL see HREADY=1, HRESP=00 and HRDATA=0 every cycle.
REQ-031 Write then read, WAIT_CYCLES=1: NONSEQ write 0x0000_0008 with HWDATA=0xDEAD_BEEF, then NONSEQ read 0x8, SHALL each give 1 cycle of HREADY=0 followed by HRDATA=0xDEAD_BEEF with OKAY.
REQ-032 Illegal addresses: NONSEQ read 0x0000_0040 (DEPTH=16) SHALL give HRESP=01/HREADY=0 then HRESP=01/HREADY=1; misaligned write 0x2 SHALL behave the same and leave mem[0] unchanged.
REQ-033 Forwarding, WAIT_CYCLES=0: back-to-back write 0xC (data 0x1234_5678) then read 0xC SHALL give HRDATA=0x1234_5678 in the read data phase with no stall.
REQ-034 Reset mid-WAIT, WAIT_CYCLES=3: write 0x4 (data 0xA5A5_A5A5) with HRESET pulsed in the second wait cycle, then read 0x4, SHALL return 0x0000_0000.
REQ-035 INCR4 burst, WAIT_CYCLES=0: NONSEQ+SEQ×3 writes to 0x10..0x1C, then a read burst, SHALL complete 4 transfers in 4 consecutive HREADY=1 cycles with the data read back intact.
